// File: rtl/sig_bounce_gen_if.sv
// sig_bounce_gen_if: command/response bundle for the contact-bounce emulator.
//   cln_sig     : clean command level (master -> slave)
//   bounce_en   : 1 = emulate bounce, 0 = bypass (master -> slave)
//   dir_sig     : emulated dirty output (slave -> master)
//   busy        : bounce window in progress (slave -> master)
//   settle_done : one-cycle pulse when dir_sig settles after a window (slave -> master)
interface sig_bounce_gen_if;
   logic cln_sig;
   logic bounce_en;
   logic dir_sig;
   logic busy;
   logic settle_done;

   modport master (output cln_sig, bounce_en, input dir_sig, busy, settle_done);
   modport slave  (input cln_sig, bounce_en, output dir_sig, busy, settle_done);
endinterface

// File: rtl/sig_bounce_gen.sv
// sig_bounce_gen: contact-bounce emulator. After each change of the clean
// command level the dirty output toggles at pseudo-random intervals for
// BOUNCE_CYCLES clocks, then settles to the commanded level.
//   clk     : clock, all state on posedge
//   reset_b : synchronous active-low reset
//   bus     : sig_bounce_gen_if.slave (cln_sig, bounce_en in; dir_sig, busy,
//             settle_done out, all outputs registered)
module sig_bounce_gen #(
   parameter int unsigned BOUNCE_CYCLES = 12,
   parameter int unsigned SEG_W         = 2,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input logic             clk,
   input logic             reset_b,
   sig_bounce_gen_if.slave bus
);

   // An all-zero seed would lock the LFSR at zero.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] BC       = 16'(BOUNCE_CYCLES);

   typedef enum logic {IDLE, BOUNCE} state_t;

   state_t      state, state_n;
   logic        cmd_q;
   logic        target, target_n;
   logic        dir_q, dir_n;
   logic        settle_q, settle_n;
   logic [15:0] win_cnt, win_n;
   logic [15:0] seg_cnt, seg_n;
   logic [15:0] lfsr, lfsr_n;
   logic [7:0]  seg_raw;
   logic [15:0] seglen;
   logic        change;

   assign change = (bus.cln_sig != cmd_q);

   // Segment length drawn from the low LFSR bits, before this edge's update.
   always_comb begin
      seg_raw               = '0;
      seg_raw[SEG_W-1:0]    = lfsr[SEG_W-1:0];
      seglen                = 16'(seg_raw) + 16'd1;
   end

   // Galois, x^16+x^14+x^13+x^11+1, shifting right.
   assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      state_n  = state;
      target_n = target;
      dir_n    = dir_q;
      settle_n = 1'b0;
      win_n    = win_cnt;
      seg_n    = seg_cnt;
      case (state)
         IDLE: begin
            if (change) begin
               if (bus.bounce_en) begin
                  target_n = bus.cln_sig;
                  dir_n    = ~dir_q;
                  win_n    = 16'd1;
                  seg_n    = seglen;
                  state_n  = BOUNCE;
               end else begin
                  dir_n = bus.cln_sig;
               end
            end
         end
         BOUNCE: begin
            win_n = win_cnt + 16'd1;
            // A new command change restarts the window, even on the settle edge.
            if (change) begin
               target_n = bus.cln_sig;
               dir_n    = ~dir_q;
               win_n    = 16'd1;
               seg_n    = seglen;
            end else if (win_cnt == BC) begin
               dir_n    = target;
               settle_n = 1'b1;
               state_n  = IDLE;
               win_n    = 16'd0;
            end else if (seg_cnt == 16'd1) begin
               dir_n = ~dir_q;
               seg_n = seglen;
            end else begin
               seg_n = seg_cnt - 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state    <= IDLE;
         cmd_q    <= 1'b0;
         target   <= 1'b0;
         dir_q    <= 1'b0;
         settle_q <= 1'b0;
         win_cnt  <= 16'd0;
         seg_cnt  <= 16'd0;
         lfsr     <= SEED_EFF;
      end else begin
         state    <= state_n;
         cmd_q    <= bus.cln_sig;
         target   <= target_n;
         dir_q    <= dir_n;
         settle_q <= settle_n;
         win_cnt  <= win_n;
         seg_cnt  <= seg_n;
         lfsr     <= lfsr_n;
      end
   end

   assign bus.dir_sig     = dir_q;
   assign bus.busy        = (state == BOUNCE);
   assign bus.settle_done = settle_q;

endmodule

// File: tb/tb_sig_bounce_gen.sv
// tb_sig_bounce_gen: randomized bench for sig_bounce_gen. A time-stamp based
// reference model predicts {dir_sig, busy, settle_done} for every clock edge
// and queues it; a monitor on the falling edge pops and compares.
module tb_sig_bounce_gen;
   localparam int          BC    = 12;
   localparam int          SEGW  = 2;
   localparam logic [15:0] SEEDV = 16'hACE1;

   logic clk = 1'b0;
   logic reset_b;
   sig_bounce_gen_if bif ();

   sig_bounce_gen #(.BOUNCE_CYCLES(BC), .SEG_W(SEGW), .SEED(SEEDV)) dut (
      .clk    (clk),
      .reset_b(reset_b),
      .bus    (bif)
   );

   always #5 clk = ~clk;

   logic [2:0] expq[$];
   int vectors = 0;
   int miscompares = 0;
   int settles = 0;

   // Reference model: the window is tracked as absolute edge numbers
   // (end of window, next toggle) rather than running counters.
   initial begin : model
      logic [15:0] lf;
      logic        prev, dir, target, inwin, settle, c;
      longint      n, t_end, t_tog;
      int          seg;
      lf = SEEDV; prev = 0; dir = 0; target = 0; inwin = 0;
      t_end = 0; t_tog = 0; n = 0;
      forever begin
         @(posedge clk);
         n++;
         settle = 0;
         c = bif.cln_sig;
         if (!reset_b) begin
            lf = SEEDV; prev = 0; dir = 0; target = 0; inwin = 0;
         end else begin
            seg = 1 + int'(lf % (16'd1 << SEGW));
            if (inwin) begin
               if (c != prev) begin
                  target = c; dir = !dir; t_end = n + BC; t_tog = n + seg;
               end else if (n == t_end) begin
                  dir = target; settle = 1; inwin = 0;
               end else if (n == t_tog) begin
                  dir = !dir; t_tog = n + seg;
               end
            end else if (c != prev) begin
               if (bif.bounce_en) begin
                  target = c; dir = !dir; inwin = 1; t_end = n + BC; t_tog = n + seg;
               end else begin
                  dir = c;
               end
            end
            prev = c;
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
         end
         expq.push_back({dir, inwin, settle});
      end
   end

   initial begin : monitor
      logic [2:0] e, a;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {bif.dir_sig, bif.busy, bif.settle_done};
            vectors++;
            if (a[0]) settles++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL outputs t=%0t: got dir=%b busy=%b sd=%b, expected dir=%b busy=%b sd=%b",
                        $time, a[2], a[1], a[0], e[2], e[1], e[0]);
            end
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin : stim
      int settles_before;
      reset_b = 0; bif.cln_sig = 1; bif.bounce_en = 1;
      step(2);
      // release with cln_sig=1: first edge starts a bounce
      reset_b = 1;
      step(30);
      // bypass
      bif.bounce_en = 0; bif.cln_sig = 0; step(20);
      bif.cln_sig = 1; step(50);
      // single bounce
      bif.bounce_en = 1; bif.cln_sig = 0; step(25);
      settles_before = settles;
      bif.cln_sig = 1; step(25);
      vectors++;
      if (settles - settles_before != 1) begin
         miscompares++;
         $display("FAIL single_settle: got %0d pulses, expected 1", settles - settles_before);
      end
      // retrigger at E5, bounce_en dropped mid-window
      settles_before = settles;
      bif.cln_sig = 0; step(5);
      bif.cln_sig = 1; bif.bounce_en = 0; step(30);
      vectors++;
      if (settles - settles_before != 1) begin
         miscompares++;
         $display("FAIL retrig_settle: got %0d pulses, expected 1", settles - settles_before);
      end
      // reset mid-window (LFSR restarts from seed)
      bif.bounce_en = 1; bif.cln_sig = 0; step(6);
      reset_b = 0; step(1);
      reset_b = 1; step(30);
      // soak
      for (int i = 0; i < 120; i++) begin
         bif.bounce_en = ($urandom_range(0, 3) != 0);
         bif.cln_sig = ~bif.cln_sig;
         if ($urandom_range(0, 5) == 0) begin
            step($urandom_range(1, 11));
            bif.cln_sig = ~bif.cln_sig;
         end
         if ($urandom_range(0, 19) == 0) begin
            step($urandom_range(1, 10));
            reset_b = 0; step(1); reset_b = 1;
         end
         step($urandom_range(40, 90));
      end
      step(2);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sig_bounce_gen.md
Name: sig_bounce_gen

Overview:
Synthesizable contact-bounce emulator. It is the transmitter-side counterpart of the sig_hys debouncer.
- Takes a clean command level and drives a "dirty" output that toggles pseudo-randomly for a fixed window after each command change, then settles to the commanded level.
- Used for on-chip self-test of the debounce/synchronizer path and in system benches feeding sig_hys.dir_sig.

Parameters:
- BOUNCE_CYCLES, 12: bounce window length in clocks, from change detection to settled output. Legal range 2..65535.
- SEG_W, 2: width of the LFSR slice that sets segment length. Segment length is 1..2^SEG_W clocks. Legal range 1..8.
- SEED, 16'hACE1: LFSR reset value. SEED==0 is replaced by 16'h0001.

Ports:
- clk, input, 1: synchronous clock.
- reset_b, input, 1: reset, synchronous, active-low.
- cln_sig, input, 1: clean command level, already synchronous to clk.
- bounce_en, input, 1: 1 = emulate bounce; 0 = bypass.
- dir_sig, output, 1: emulated dirty output, registered.
- busy, output, 1: high while in BOUNCE, registered.
- settle_done, output, 1: one-cycle pulse on the edge dir_sig settles after a bounce window, registered.

Behaviour:
- Clocking and reset:
  - One clock, clk. All state updates on posedge clk.
  - reset_b is synchronous, active-low: sampled only at posedge clk.
  - Reset values: dir_sig=0, busy=0, settle_done=0, state=IDLE, cmd_q=0, target=0, win_cnt=0, seg_cnt=0, lfsr=SEED (or 1 if SEED==0).
- Change detection: cmd_q holds the previous sampled cln_sig. A change is cln_sig != cmd_q at a clock edge. cmd_q <= cln_sig every non-reset edge.
- LFSR:
  - 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1), shift right.
  - Advances every non-reset edge regardless of state.
  - seglen = 1 + lfsr[SEG_W-1:0], using the lfsr value before the update.
- States: IDLE, BOUNCE. busy mirrors state==BOUNCE.
- IDLE, no change: hold dir_sig; settle_done=0.
- IDLE, change, bounce_en=0: dir_sig <= cln_sig on the detecting edge (1-clock latency from cln_sig). Stay IDLE. No settle_done.
- IDLE, change, bounce_en=1, on detecting edge E0:
  - target <= cln_sig; dir_sig <= ~dir_sig; win_cnt <= 1; seg_cnt <= seglen; state <= BOUNCE.
- BOUNCE, each edge:
  - win_cnt increments.
  - If win_cnt==BOUNCE_CYCLES: dir_sig <= target; settle_done <= 1; state <= IDLE; win_cnt <= 0. This is edge E_BOUNCE_CYCLES.
  - Else if seg_cnt==1: dir_sig <= ~dir_sig; seg_cnt <= seglen.
  - Else: seg_cnt decrements.
- BOUNCE, change on cln_sig:
  - Window restarts: target <= cln_sig; win_cnt <= 1; seg_cnt <= seglen.
  - dir_sig toggles on that edge.
  - Restart takes priority over settle on the same edge.
- bounce_en is sampled only in IDLE on a change. Deasserting it mid-BOUNCE does not shorten the window.
- settle_done is high for exactly one cycle. It is never asserted on bypass updates.
- Width rules: win_cnt and seg_cnt are 16 bits. seg_cnt reaches at most 256. No wrap is possible within legal parameters.
- Reset mid-BOUNCE: reset values apply on the next edge with reset_b=0. No settle_done is emitted. A pending target is discarded.

Test Plan:
1. Reset with defaults: hold reset_b=0 for 2 clocks with cln_sig=1 -> dir_sig=0, busy=0, settle_done=0. After release, the first edge detects the change: bypass or BOUNCE according to bounce_en.
2. Bypass: bounce_en=0, cln_sig 0->1 -> dir_sig=1 exactly 1 clock later. busy stays 0. settle_done stays 0. No further toggles for 50 clocks.
3. Single bounce (BOUNCE_CYCLES=12, SEG_W=2):
   - cln_sig 0->1 -> dir_sig=1 at E0; busy=1 for edges E0..E11.
   - Inter-toggle spacing within E0..E11 is always 1..4 clocks.
   - dir_sig=1 from E12 onward; settle_done high only in the cycle after E12.
   - Cycle-exact match with the golden LFSR model from SEED=16'hACE1.
4. Retrigger: cln_sig 0->1, then 1->0 at E5 -> window restarts. dir_sig settles to 0 at E5+12, one settle_done pulse only, busy continuous.
5. Reset mid-window: reset_b=0 at E6 for 1 clock -> dir_sig=0, busy=0, no settle_done. The LFSR sequence restarts from SEED.
6. Loopback soak: dir_sig drives sig_hys (TURN_ON=7, TURN_OFF=10); random cln_sig with hold >=40 clocks for 10k cycles.
   - fil_sig has exactly one edge per cln_sig change.
   - Matches cln_sig delayed by 12 + debounce latency.
   - Zero mismatches against the scoreboard.
